// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: scan control and digit data in,
// registered segment/digit drives and frame pulse out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic                    frame_done;

  modport master (
    output en, load, digits, dp_in,
    input  seg_n, dig_n, frame_done
  );

  modport slave (
    input  en, load, digits, dp_in,
    output seg_n, dig_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow-registered digit data.
// Define SEG7_LEADING_ZERO_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_driver_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TC = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc;
  logic                    wrap;
  logic [3:0]              code;
  logic                    dp_sel;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   blk;
  logic [NUM_DIGITS-1:0]   dig_sel;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
      4'hB: s = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
      4'hC: s = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
      4'hD: s = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
      4'hE: s = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
      default: s = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    tc       = (cnt_q == CNT_TC);
    wrap     = bus.en && tc && (idx_q == IDX_TC);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (bus.en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
      if (tc) idx_d = (idx_q == IDX_TC) ? '0 : idx_q + IW'(1);
    end
    shadow_d = bus.load ? bus.digits : shadow_q;
    dp_d     = bus.load ? bus.dp_in : dp_q;
    // Wrap may land while disabled; hold it until digit 0 is shown.
    pend_d       = wrap | (pend_q & ~bus.en);
    frame_done_d = bus.en & pend_q;
  end

  always_comb begin
    blk = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin : lzb
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lead && shadow_q[4*i +: 4] == 4'h0 && !dp_q[i]) blk[i] = 1'b1;
        else lead = 1'b0;
      end
    end
`else
    blk = '0;
`endif
  end

  always_comb begin
    code    = '0;
    dp_sel  = 1'b0;
    blank   = 1'b0;
    dig_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        code       = shadow_q[4*i +: 4];
        dp_sel     = dp_q[i];
        blank      = blk[i];
        dig_sel[i] = 1'b0;
      end
    end
    seg_n_d = 8'hFF;
    dig_n_d = '1;
    if (bus.en) begin
      dig_n_d = dig_sel;
      if (!blank) seg_n_d = {~dp_sel, decode(code)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      dp_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      seg_n_q      <= 8'hFF;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      dp_q         <= dp_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.dig_n      = dig_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: vector table, corner sequences and a
// randomized run against an arithmetic display model.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int S = 4;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [7:0] Z = LZB ? 8'hFF : 8'hC0;
  localparam logic [7:0] DEC [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] HEXT [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1,
    8'h86, 8'h8E};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en, load;
  logic [15:0] dg;
  logic [3:0]  dpi;
  logic        en2, load2;
  logic [3:0]  dg2;
  logic [0:0]  dp2;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) b0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) b1 ();
  seg7_scan_driver_if #(.NUM_DIGITS(1)) b2 ();

  assign b0.en = en;  assign b0.load = load;
  assign b0.digits = dg; assign b0.dp_in = dpi;
  assign b1.en = en;  assign b1.load = load;
  assign b1.digits = dg; assign b1.dp_in = dpi;
  assign b2.en = en2; assign b2.load = load2;
  assign b2.digits = dg2; assign b2.dp_in = dp2;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1));
  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(3), .HEX_MODE(0)) u2 (
    .clk(clk), .rst(rst), .bus(b2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: enabled-clock count plus the loaded digit values.
  int         en_cnt;
  logic [3:0] sh [4];
  bit         shdp [4];

  function automatic logic [7:0] ref_seg(input logic [3:0] c,
                                         input bit dpb, input bit hex);
    logic [7:0] s;
    if (c < 4'd10) s = DEC[c];
    else if (hex) s = HEXT[c - 4'd10];
    else s = 8'hFF;
    if (dpb) s[7] = 1'b0;
    return s;
  endfunction

  function automatic bit lz_blank(input int d);
    bit b;
    b = LZB && (d > 0);
    for (int i = d; i < N; i++)
      if (sh[i] != 4'h0 || shdp[i]) b = 1'b0;
    return b;
  endfunction

  function automatic void model_clear();
    en_cnt = 0;
    for (int i = 0; i < N; i++) begin
      sh[i] = 4'h0;
      shdp[i] = 1'b0;
    end
  endfunction

  task automatic tick();
    logic [7:0] e0, e1;
    logic [3:0] ed;
    logic       efd;
    int         d;
    e0 = 8'hFF; e1 = 8'hFF; ed = 4'hF; efd = 1'b0;
    if (en) begin
      d = (en_cnt / S) % N;
      ed[d] = 1'b0;
      if (!lz_blank(d)) begin
        e0 = ref_seg(sh[d], shdp[d], 1'b0);
        e1 = ref_seg(sh[d], shdp[d], 1'b1);
      end
      efd = (en_cnt > 0) && (en_cnt % (N * S) == 0);
      en_cnt++;
    end
    if (load)
      for (int i = 0; i < N; i++) begin
        sh[i] = dg[4*i +: 4];
        shdp[i] = dpi[i];
      end
    @(posedge clk);
    @(negedge clk);
    chk("seg_hex0", b0.seg_n, e0);
    chk("seg_hex1", b1.seg_n, e1);
    chk("dig_n", b0.dig_n, ed);
    chk("frame_done", b0.frame_done, efd);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_seg", b0.seg_n, 8'hFF);
    chk("rst_dig", b0.dig_n, 4'hF);
    chk("rst_fd", b0.frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0]     dg;
    logic [3:0]      dp;
    logic [3:0][7:0] e0;
    logic [3:0][7:0] e1;
  } vec_t;

  vec_t tv [7];
  logic [3:0][7:0] got0, got1;
  int fd_t [$];
  int t0;

  initial begin
    tv[0] = '{16'h1234, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99},
                              {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    tv[1] = '{16'h00AF, 4'h1, {Z, Z, 8'hFF, 8'h7F},
                              {Z, Z, 8'h88, 8'h0E}};
    tv[2] = '{16'h0070, 4'h0, {Z, Z, 8'hF8, 8'hC0},
                              {Z, Z, 8'hF8, 8'hC0}};
    tv[3] = '{16'h5555, 4'h0, {4{8'h92}}, {4{8'h92}}};
    tv[4] = '{16'h8888, 4'hF, {4{8'h00}}, {4{8'h00}}};
    tv[5] = '{16'h0000, 4'h0, {Z, Z, Z, 8'hC0}, {Z, Z, Z, 8'hC0}};
    tv[6] = '{16'h0B0C, 4'h4, {Z, 8'h7F, 8'hC0, 8'hFF},
                              {Z, 8'h03, 8'hC0, 8'hC6}};

    rst = 1'b1; en = 1'b0; load = 1'b0; dg = '0; dpi = '0;
    en2 = 1'b0; load2 = 1'b0; dg2 = '0; dp2 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("init_seg", b0.seg_n, 8'hFF);
    chk("init_dig", b0.dig_n, 4'hF);
    chk("init_fd", b0.frame_done, 1'b0);
    rst = 1'b0;

    // Vector table: capture each digit's pattern over a full frame
    foreach (tv[k]) begin
      do_reset();
      en = 1'b1; dg = tv[k].dg; dpi = tv[k].dp; load = 1'b1;
      tick();
      load = 1'b0; dg = 16'hFFFF; dpi = 4'h0;
      got0 = 'x; got1 = 'x;
      repeat (20) begin
        tick();
        for (int j = 0; j < N; j++)
          if (b0.dig_n == ~(4'b1 << j)) begin
            got0[j] = b0.seg_n;
            got1[j] = b1.seg_n;
          end
      end
      for (int j = 0; j < N; j++) begin
        chk($sformatf("vec%0d_d%0d_hex0", k, j), got0[j], tv[k].e0[j]);
        chk($sformatf("vec%0d_d%0d_hex1", k, j), got1[j], tv[k].e1[j]);
      end
    end

    // Frame period: no pulse at start, then every N*S clocks
    do_reset();
    en = 1'b1; dg = 16'h1234; load = 1'b1;
    fd_t.delete();
    for (int t = 1; t <= 40; t++) begin
      tick();
      load = 1'b0;
      if (b0.frame_done) fd_t.push_back(t);
    end
    chk("fd_count", fd_t.size(), 2);
    if (fd_t.size() == 2) begin
      chk("fd_first", fd_t[0], 17);
      chk("fd_period", fd_t[1] - fd_t[0], 16);
    end

    // Mid-frame reset, then a full dwell on digit 0
    do_reset();
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("post_rst_dwell", b0.dig_n, 4'hE);
    end
    tick();
    chk("post_rst_next", b0.dig_n, 4'hD);

    // Load coincident with digit 0 terminal count
    do_reset();
    dg = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    dg = 16'h5555; load = 1'b1;
    tick();
    chk("tc_load_still_d0", b0.dig_n, 4'hE);
    load = 1'b0;
    tick();
    chk("tc_load_dig", b0.dig_n, 4'hD);
    chk("tc_load_seg", b0.seg_n, 8'h92);

    // Enable gap of 10 clocks stretches the frame by 10
    do_reset();
    dg = 16'h1234; load = 1'b1;
    fd_t.delete();
    t0 = 0;
    for (int t = 1; t <= 40 && fd_t.size() == 0; t++) begin
      if (t == 7) en = 1'b0;
      if (t == 17) en = 1'b1;
      tick();
      load = 1'b0;
      if (!en) begin
        chk("gap_seg", b0.seg_n, 8'hFF);
        chk("gap_dig", b0.dig_n, 4'hF);
      end
      if (b0.frame_done) fd_t.push_back(t);
    end
    chk("gap_fd_seen", fd_t.size(), 1);
    if (fd_t.size() == 1) chk("gap_fd_time", fd_t[0], 27);

    // Single-digit instance
    do_reset();
    en2 = 1'b1; load2 = 1'b1; dg2 = 4'h7; dp2 = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      @(negedge clk);
      load2 = 1'b0;
      chk("n1_dig", b2.dig_n, 1'b0);
      chk("n1_seg", b2.seg_n, (t == 0) ? 8'hC0 : 8'h78);
      chk("n1_fd", b2.frame_done, (t > 0) && (t % 3 == 0));
    end
    en2 = 1'b0;

    // Randomized run with zero-biased digits
    do_reset();
    for (int t = 0; t < 400; t++) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++)
        dg[4*i +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0
                       : 4'($urandom_range(0, 15));
      dpi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, meaning clocks per digit dwell, legal range 2..2^20.
REQ-003 The block SHALL have parameter HEX_MODE, default 0, meaning codes 10..15 are blanked when 0 and shown as A..F when 1.
REQ-004 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scan enable; 0 SHALL freeze scanning and blank outputs.
REQ-007 load  input  1  single-cycle strobe capturing digits/dp_in into the shadow register.
REQ-008 digits  input  4*NUM_DIGITS  BCD/hex codes; nibble i drives digit i, where digit 0 is least significant.
REQ-009 dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-010 seg_n  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-011 dig_n  output  NUM_DIGITS  active-low one-hot digit select, registered.
REQ-012 frame_done  output  1  one-cycle pulse when the scan index wraps from NUM_DIGITS-1 to 0.

Function
REQ-013 Segment patterns for codes 0..9 SHALL be, in hex: C0,F9,A4,B0,99,92,82,F8,80,90, with the dp bit overridden to 0 when dp is set for that digit.
REQ-014 With HEX_MODE=1, codes A..F SHALL map to 88,83,C6,A1,86,8E; with HEX_MODE=0, codes 10..15 SHALL give seg_n[6:0]=7F, with dp still honoured.
REQ-015 Display data SHALL come only from the shadow register, so that changing digits without load has no visible effect.
REQ-016 load=1 SHALL update the shadow register on that edge, and the new data SHALL appear at the outputs on the following edge if the digit is currently selected.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 while en=1; at the terminal count it SHALL return to 0 and advance the digit index, wrapping from NUM_DIGITS-1 to 0.
REQ-018 Each digit SHALL therefore be selected for exactly SCAN_DIV clocks, and a full frame SHALL last NUM_DIGITS*SCAN_DIV clocks.
REQ-019 seg_n and dig_n SHALL be registered together, one clock after the index or shadow register changes, and SHALL never show a mismatched digit/segment pair.
REQ-020 frame_done SHALL assert in the same cycle that dig_n first selects digit 0 after a wrap, and SHALL not assert when scanning starts after reset.
REQ-021 When en=0, the counter and index SHALL hold, seg_n SHALL be FF, and dig_n SHALL be all ones from the next edge; when en returns to 1, scanning SHALL resume from the held index and count.
REQ-022 If load and a terminal count occur in the same cycle, the newly selected digit SHALL show the newly loaded data.
REQ-023 With NUM_DIGITS=1, the index SHALL stay 0, dig_n SHALL be constantly 0 while enabled, and frame_done SHALL pulse every SCAN_DIV clocks.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force the following: shadow register=0, dp shadow=0, counter=0, index=0, seg_n=FF, dig_n=all ones, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame, and after release the first selected digit SHALL be digit 0 with a full SCAN_DIV dwell.

Configuration
REQ-026 The macro SEG7_LEADING_ZERO_BLANK_EN SHALL control leading-zero suppression.
REQ-027 With SEG7_LEADING_ZERO_BLANK_EN defined, a digit with code 0 and its dp clear SHALL be blanked (seg_n=FF, still selected) when all more-significant digits are also blanked; digit 0 SHALL never be blanked.
REQ-028 Without the macro, every digit SHALL be decoded per REQ-013/REQ-014 with no suppression.

Verification
REQ-029 Reset check: assert rst mid-frame, NUM_DIGITS=4 -> seg_n=FF and dig_n=4'hF immediately; after release, dig_n=4'hE for SCAN_DIV=4 clocks.
REQ-030 Scan order: SCAN_DIV=4, load digits=16'h1234 -> dig_n sequence E,D,B,7 with seg_n 99,B0,A4,F9; frame_done pulses once every 16 clocks.
REQ-031 Hex/blank: HEX_MODE=0, load digits=16'h00AF with dp_in=4'b0001 -> digit 0 seg_n=7F, digit 1 seg_n=FF; repeat with HEX_MODE=1 -> digit 0 seg_n=0E, digit 1 seg_n=88.
REQ-032 Simultaneous events: assert load with digits=16'h5555 on the terminal-count cycle of digit 0 -> digit 1 shows 92 in its first displayed cycle.
REQ-033 Enable: deassert en for 10 clocks mid-dwell -> outputs blank and frame length extends by exactly 10 clocks.
REQ-034 Macro: with SEG7_LEADING_ZERO_BLANK_EN defined, digits=16'h0070 -> digits 3 and 2 give FF, digit 1 gives F8, digit 0 gives C0; without the macro, digits 3 and 2 give C0.
